pdm_fir_decim_mc: RTL and testbench

Multi-channel PDM-to-PCM decimating FIR for MEMS microphones. It replaces the fixed single-channel filter with parametrised taps, lanes, channels and decimation, runtime-loadable coefficients, and a programmable offset. Output is saturated and time-multiplexed per channel. The block sits between the PDM pins, which are sampled on the sclk rising edge, and the MFCC front end.

---
 rtl/pdm_fir_decim_mc_if.sv | 17 +
 rtl/pdm_fir_decim_mc.sv | 157 +++++++++++++++
 tb/tb_pdm_fir_decim_mc.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_fir_decim_mc_if.sv
// pdm_fir_decim_mc_if: coefficient write port and time-multiplexed PCM output bus
interface pdm_fir_decim_mc_if #(
    parameter int AW  = 9,
    parameter int CW  = 16,
    parameter int OW  = 16,
    parameter int CHW = 1
);
    logic                  coef_we;
    logic [AW-1:0]         coef_addr;
    logic signed [CW-1:0]  coef_data;
    logic                  coef_rdy;
    logic signed [OW-1:0]  pcm_o;
    logic [CHW-1:0]        pcm_ch;
    logic                  dv;
    modport master (output coef_we, coef_addr, coef_data, input coef_rdy, pcm_o, pcm_ch, dv);
    modport slave  (input coef_we, coef_addr, coef_data, output coef_rdy, pcm_o, pcm_ch, dv);
endinterface

// File: rtl/pdm_fir_decim_mc.sv
// pdm_fir_decim_mc: multi-channel PDM-to-PCM decimating FIR with loadable taps and saturated output
module pdm_fir_decim_mc #(
    parameter int NCH   = 2,
    parameter int TAPS  = 512,
    parameter int LANES = 32,
    parameter int DEC   = 1,
    parameter int CW    = 16,
    parameter int OW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic [NCH-1:0]       pdm_i,
    input  logic                 enable,
    input  logic signed [OW-1:0] offset,
    pdm_fir_decim_mc_if.slave    bus,
    output logic                 busy,
    output logic                 overrun
);
    localparam int DEPTH = TAPS / LANES;
    localparam int AW    = $clog2(TAPS);
    localparam int CHW   = NCH > 1 ? $clog2(NCH) : 1;
    localparam int ACCW  = CW + AW;
    localparam int LG    = $clog2(LANES);
    localparam int BW    = LANES > 1 ? LG : 1;
    localparam int KW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int SW    = (ACCW > OW ? ACCW : OW) + 1;
    localparam logic signed [SW-1:0] YMAX = SW'(2 ** (OW - 1) - 1);
    localparam logic signed [SW-1:0] YMIN = ~YMAX;

    typedef enum logic [2:0] {IDLE, SHIFT, ACC, TREE, OUT} state_t;

    state_t                 state, state_n;
    logic [2:0]             sync;
    logic                   sedge, wrap, pend_v;
    logic [NCH-1:0]         pend, sh_bits;
    logic [7:0]             dcnt;
    logic [CHW-1:0]         ch;
    logic [KW-1:0]          k;
    logic [BW-1:0]          lvl;
    logic [TAPS-1:0]        hist [NCH];
    logic [TAPS-1:0]        cur;
    logic [DEPTH-1:0]       seg [LANES];
    logic signed [CW-1:0]   coef_mem [LANES][DEPTH];
    logic signed [ACCW-1:0] acc [LANES];
    logic signed [SW-1:0]   diff;
    logic signed [OW-1:0]   y;

    assign sedge = sync[1] & ~sync[2];
    assign wrap  = dcnt == 8'(DEC - 1);
    assign cur   = hist[ch];

    for (genvar l = 0; l < LANES; l++) begin : g_seg
        assign seg[l] = cur[l*DEPTH +: DEPTH];
    end

    // two-stage sclk synchroniser plus one delay stage for rising-edge detect
    always_ff @(posedge clk or negedge reset)
        if (!reset) sync <= '0;
        else sync <= {sync[1:0], sclk};

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_n;

    // next state; coefficient writes are only accepted while idle
    always_comb begin
        state_n = state;
        busy = state != IDLE;
        bus.coef_rdy = state == IDLE;
        case (state)
            IDLE:  if (enable && (pend_v || sedge)) state_n = SHIFT;
            SHIFT: state_n = wrap ? ACC : IDLE;
            ACC:   if (k == KW'(DEPTH - 1)) state_n = LG > 0 ? TREE : OUT;
            TREE:  if (lvl == BW'(LG - 1)) state_n = OUT;
            OUT:   state_n = ch == CHW'(NCH - 1) ? IDLE : ACC;
            default: state_n = IDLE;
        endcase
    end

    // coefficient banks: tap n lives in bank n/DEPTH at entry n%DEPTH
    always_ff @(posedge clk)
        if (bus.coef_we && bus.coef_rdy)
            coef_mem[BW'(bus.coef_addr / AW'(DEPTH))][KW'(bus.coef_addr % AW'(DEPTH))] <= bus.coef_data;

    // offset removal and clamp of the tree result to the output range
    always_comb begin
        diff = SW'(acc[0]) - SW'(offset);
        y = diff > YMAX ? OW'(YMAX) : diff < YMIN ? OW'(YMIN) : OW'(diff);
    end

    // pending sample, history shift, lane accumulation, adder tree and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            pend_v <= 1'b0;
            sh_bits <= '0;
            overrun <= 1'b0;
            dcnt <= '0;
            ch <= '0;
            k <= '0;
            lvl <= '0;
            bus.pcm_o <= '0;
            bus.pcm_ch <= '0;
            bus.dv <= 1'b0;
            for (int c = 0; c < NCH; c++) hist[c] <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else begin
            bus.dv <= 1'b0;
            if (!enable) begin
                pend_v <= 1'b0;
                overrun <= 1'b0;
            end else if (state == IDLE) begin
                sh_bits <= pend_v ? pend : pdm_i;
                if (pend_v) begin
                    pend <= pdm_i;
                    pend_v <= sedge;
                end
            end else if (sedge) begin
                if (pend_v) overrun <= 1'b1;
                else begin
                    pend <= pdm_i;
                    pend_v <= 1'b1;
                end
            end
            case (state)
                SHIFT: begin
                    for (int c = 0; c < NCH; c++) hist[c] <= {hist[c][TAPS-2:0], sh_bits[c]};
                    dcnt <= wrap ? '0 : dcnt + 1'b1;
                    ch <= '0;
                    k <= '0;
                    for (int l = 0; l < LANES; l++) acc[l] <= '0;
                end
                ACC: begin
                    for (int l = 0; l < LANES; l++)
                        if (seg[l][k]) acc[l] <= acc[l] + ACCW'(coef_mem[l][k]);
                    k <= k + 1'b1;
                    lvl <= '0;
                end
                TREE: begin
                    for (int i = 0; i < LANES / 2; i++) acc[i] <= acc[2 * i] + acc[2 * i + 1];
                    lvl <= lvl + 1'b1;
                end
                OUT: begin
                    bus.pcm_o <= y;
                    bus.pcm_ch <= ch;
                    bus.dv <= 1'b1;
                    ch <= ch + 1'b1;
                    k <= '0;
                    for (int l = 0; l < LANES; l++) acc[l] <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pdm_fir_decim_mc.sv
// tb_pdm_fir_decim_mc: randomized scoreboard bench against an arithmetic FIR reference model
module tb_pdm_fir_decim_mc;
    localparam int NCH = 2, TAPS = 512, LANES = 32, DEC = 1, CW = 16, OW = 16;
    localparam int AW = $clog2(TAPS), CHW = 1, GAP = 50;
    localparam int SPACING = TAPS / LANES + $clog2(LANES) + 1;

    typedef struct {int ch; int val;} exp_t;

    logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, enable = 1'b0;
    logic [NCH-1:0] pdm_i = '0;
    logic signed [OW-1:0] offset = '0;
    logic busy, overrun;

    exp_t q[$];
    exp_t e_m;
    bit   mh [NCH][TAPS];
    int   h [TAPS];
    int   n_cmp = 0, n_bad = 0, cyc = 0, last_dv = 0, dv_off = 0, dcnt_m = 0;
    bit   sb_on = 1'b1, prev_dv = 1'b0;

    pdm_fir_decim_mc_if #(.AW(AW), .CW(CW), .OW(OW), .CHW(CHW)) bus ();

    pdm_fir_decim_mc #(.NCH(NCH), .TAPS(TAPS), .LANES(LANES), .DEC(DEC), .CW(CW), .OW(OW)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .pdm_i(pdm_i), .enable(enable),
        .offset(offset), .bus(bus), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, longint act, longint want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // reference: history as a bit array, output = sum of h[n] over set bits, minus offset, clamped
    task automatic model_edge(logic [NCH-1:0] b);
        for (int c = 0; c < NCH; c++) begin
            for (int n = TAPS - 1; n > 0; n--) mh[c][n] = mh[c][n-1];
            mh[c][0] = b[c];
        end
        dcnt_m = (dcnt_m + 1) % DEC;
        if (dcnt_m == 0)
            for (int c = 0; c < NCH; c++) begin
                longint s = 0;
                for (int n = 0; n < TAPS; n++) if (mh[c][n]) s += h[n];
                s -= int'(offset);
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
                q.push_back('{c, int'(s)});
            end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) for (int n = 0; n < TAPS; n++) mh[c][n] = 1'b0;
        dcnt_m = 0;
    endtask

    task automatic send(logic [NCH-1:0] b, int gap, bit model);
        @(negedge clk);
        pdm_i = b;
        sclk = 1'b1;
        if (model && enable) model_edge(b);
        repeat (gap / 2) @(negedge clk);
        sclk = 1'b0;
        repeat (gap - gap / 2 - 1) @(negedge clk);
    endtask

    task automatic push_coefs();
        for (int n = 0; n < TAPS; n++) begin
            @(negedge clk);
            bus.coef_we = 1'b1;
            bus.coef_addr = AW'(n);
            bus.coef_data = CW'(h[n]);
        end
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // monitor: pops the scoreboard on every dv and checks spacing between channels
    always @(negedge clk) begin
        cyc++;
        if (bus.dv) begin
            chk("dv_not_back_to_back", prev_dv, 0);
            if (bus.pcm_ch != '0) chk("ch_spacing", cyc - last_dv, SPACING);
            last_dv = cyc;
            if (!sb_on) dv_off++;
            else begin
                chk("dv_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e_m = q.pop_front();
                    chk("pcm_ch", bus.pcm_ch, e_m.ch);
                    chk("pcm_o", bus.pcm_o, e_m.val);
                end
            end
        end
        prev_dv = bus.dv;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected run completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int wt, snap;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pcm_o", bus.pcm_o, 0);
        chk("rst_pcm_ch", bus.pcm_ch, 0);
        chk("rst_dv", bus.dv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_coef_rdy", bus.coef_rdy, 1);
        reset = 1'b1;
        enable = 1'b1;

        // all-ones coefficients and input: output climbs to 512 on both channels
        for (int n = 0; n < TAPS; n++) h[n] = 1;
        push_coefs();
        for (int i = 0; i < TAPS; i++) send(2'b11, GAP, 1'b1);
        drain();

        // positive and negative saturation on a full-ones history
        for (int n = 0; n < TAPS; n++) h[n] = 100;
        push_coefs();
        send(2'b11, GAP, 1'b1);
        drain();
        for (int n = 0; n < TAPS; n++) h[n] = -100;
        push_coefs();
        send(2'b11, GAP, 1'b1);
        drain();

        // random coefficients, offset and PDM bits
        for (int n = 0; n < TAPS; n++) h[n] = int'($urandom_range(400)) - 200;
        push_coefs();
        offset = OW'(int'($urandom_range(2000)) - 1000);
        repeat (100) send(NCH'($urandom), GAP, 1'b1);
        drain();
        offset = '0;

        // overrun: edges faster than a frame; enable low clears the flag
        sb_on = 1'b0;
        send(2'b10, 10, 1'b0);
        send(2'b01, 10, 1'b0);
        chk("overrun_after_pending", overrun, 0);
        send(2'b11, 10, 1'b0);
        chk("overrun_set", overrun, 1);
        chk("frame_still_busy", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", overrun, 0);
        wt = 0;
        while (busy && wt < 300) begin
            @(negedge clk);
            wt++;
        end
        chk("overrun_frames_done", busy, 0);
        enable = 1'b1;
        pulse_reset();
        sb_on = 1'b1;

        // all-zero history with most negative offset clamps high
        for (int n = 0; n < TAPS; n++) h[n] = 1;
        push_coefs();
        offset = 16'sh8000;
        send(2'b00, GAP, 1'b1);
        drain();
        offset = '0;

        // impulse on channel 0 walks through h[n]=n; a busy-time write must not land
        for (int n = 0; n < TAPS; n++) h[n] = n;
        push_coefs();
        for (int i = 0; i < 64; i++) begin
            if (i == 3) begin
                @(negedge clk);
                pdm_i = 2'b00;
                sclk = 1'b1;
                model_edge(2'b00);
                wt = 0;
                while (!busy && wt < 20) begin
                    @(negedge clk);
                    wt++;
                end
                chk("busy_seen", busy, 1);
                bus.coef_we = 1'b1;
                bus.coef_addr = 9'd40;
                bus.coef_data = 16'sd9999;
                repeat (4) begin
                    chk("coef_rdy_busy", bus.coef_rdy, 0);
                    @(negedge clk);
                end
                bus.coef_we = 1'b0;
                sclk = 1'b0;
                repeat (GAP) @(negedge clk);
            end else send(i == 0 ? 2'b01 : 2'b00, GAP, 1'b1);
        end
        drain();

        // reset during ACC: outputs drop at once and no dv follows
        for (int n = 0; n < TAPS; n++) h[n] = 1;
        push_coefs();
        send(2'b11, GAP, 1'b1);
        drain();
        sb_on = 1'b0;
        @(negedge clk);
        pdm_i = 2'b11;
        sclk = 1'b1;
        wt = 0;
        while (!busy && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk("busy_before_reset", busy, 1);
        repeat (11) @(negedge clk);
        snap = dv_off;
        reset = 1'b0;
        #1;
        chk("midrst_pcm_o", bus.pcm_o, 0);
        chk("midrst_pcm_ch", bus.pcm_ch, 0);
        chk("midrst_dv", bus.dv, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_overrun", overrun, 0);
        sclk = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (30) @(negedge clk);
        chk("no_dv_after_reset", dv_off, snap);
        sb_on = 1'b1;
        for (int i = 0; i < TAPS; i++) send(2'b11, GAP, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
